// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and default sizes for the shared-adder arbiter.
package adder_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW      = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between client blocks (master) and the shared adder (slave).
interface adder_share_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [DW:0]           rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant_i, wrapping.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_grant_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_idx_o
);

    logic           found;
    logic [IDW-1:0] idx;

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(last_grant_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one DW-bit adder among NUM_REQ clients: accept in IDLE, add in CALC, hold result in RESP.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW
) (
    input logic                 clk,
    input logic                 rst,
    adder_share_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [DW-1:0]  op_a_q, op_a_d;
    logic [DW-1:0]  op_b_q, op_b_d;
    logic [DW:0]    rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] req_ready_w;
    logic               accept;
    logic [DW-1:0]      a_arr [NUM_REQ];
    logic [DW-1:0]      b_arr [NUM_REQ];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = bus.req_a[i*DW +: DW];
            b_arr[i] = bus.req_b[i*DW +: DW];
        end
    end

    // Grants are offered only in IDLE and never while reset is held.
    assign req_ready_w = (state_q == IDLE && !rst) ? gnt : '0;
    assign accept      = |req_ready_w;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d     = a_arr[gnt_idx];
                    op_b_d     = b_arr[gnt_idx];
                    grant_id_d = gnt_idx;
                    state_d    = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = {1'b0, op_a_q} + {1'b0, op_b_q};
                rsp_id_d    = grant_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: latency, operand extremes, round-robin, backpressure, reset.
module tb_adder_share_arbiter;
    import adder_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   k;

    adder_share_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();

    adder_share_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid[id]        = v;
        bus.req_a[id*DW +: DW]   = a;
        bus.req_b[id*DW +: DW]   = b;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid) break;
            @(negedge clk);
        end
        check({tag, "_rsp_arrived"}, 32'(bus.rsp_valid), 1);
    endtask

    // Called at a negedge in IDLE; leaves the bench at a negedge back in IDLE.
    task automatic run_txn(input string tag, input int id, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input int exp_ready, input int exp_sum);
        set_req(id, 1'b1, a, b);
        #1 check({tag, "_ready"}, 32'(bus.req_ready), exp_ready);
        @(posedge clk);
        @(negedge clk);
        set_req(id, 1'b0, a, b);
        wait_rsp(tag);
        check({tag, "_sum"}, 32'(bus.rsp_sum), exp_sum);
        check({tag, "_id"}, 32'(bus.rsp_id), id);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_done"}, 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, including no grant while reset is held.
        @(negedge clk);
        bus.req_valid = 4'b0001;
        #1;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_valid", 32'(bus.rsp_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_sum", 32'(bus.rsp_sum), 0);
        check("rst_id", 32'(bus.rsp_id), 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Single request with exact latency: rsp_valid two edges after accept.
        @(negedge clk);
        set_req(0, 1'b1, 4'd5, 4'd5);
        #1 check("t1_ready", 32'(bus.req_ready), 32'b0001);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 4'd5, 4'd5);
        check("t1_calc_busy", 32'(bus.busy), 1);
        check("t1_calc_ready", 32'(bus.req_ready), 0);
        check("t1_calc_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 1);
        check("t1_rsp_sum", 32'(bus.rsp_sum), 10);
        check("t1_rsp_id", 32'(bus.rsp_id), 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("t1_idle_valid", 32'(bus.rsp_valid), 0);
        check("t1_idle_busy", 32'(bus.busy), 0);

        // Max operands on requester 2.
        run_txn("max", 2, 4'd15, 4'd15, 32'b0100, 30);

        // Wrap-around after grant to 2: requester 3 wins over 0, then 0 (with 0+0).
        set_req(0, 1'b1, 4'd0, 4'd0);
        run_txn("wrap3", 3, 4'd9, 4'd6, 32'b1000, 15);
        run_txn("wrap0", 0, 4'd0, 4'd0, 32'b0001, 0);

        // Round-robin from reset with all four continuously valid.
        rst = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, DW'(i), DW'(i + 1));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                check("rr_id", 32'(bus.rsp_id), k % NR);
                check("rr_sum", 32'(bus.rsp_sum), 2 * (k % NR) + 1);
                k++;
                if (k == 5) break;
            end
        end
        check("rr_count", 32'(k), 5);
        bus.req_valid = '0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rr_idle", 32'(bus.rsp_valid), 0);

        // Backpressure: result held, no grants while RESP waits.
        set_req(2, 1'b1, 4'd3, 4'd4);
        #1 check("bp_ready2", 32'(bus.req_ready), 32'b0100);
        @(posedge clk);
        @(negedge clk);
        set_req(2, 1'b0, 4'd3, 4'd4);
        wait_rsp("bp");
        set_req(1, 1'b1, 4'd6, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(bus.rsp_valid), 1);
            check("bp_hold_sum", 32'(bus.rsp_sum), 7);
            check("bp_hold_id", 32'(bus.rsp_id), 2);
            check("bp_hold_busy", 32'(bus.busy), 1);
            check("bp_hold_ready", 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("bp_release_valid", 32'(bus.rsp_valid), 0);
        check("bp_release_ready1", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 4'd6, 4'd1);
        check("bp_r1_busy", 32'(bus.busy), 1);
        wait_rsp("bp_r1");
        check("bp_r1_sum", 32'(bus.rsp_sum), 7);
        check("bp_r1_id", 32'(bus.rsp_id), 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Reset during CALC: transaction dropped, priority back to requester 0.
        set_req(3, 1'b1, 4'd7, 4'd8);
        #1 check("mid_ready3", 32'(bus.req_ready), 32'b1000);
        @(posedge clk);
        @(negedge clk);
        check("mid_calc_busy", 32'(bus.busy), 1);
        set_req(0, 1'b1, 4'd1, 4'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_valid", 32'(bus.rsp_valid), 0);
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        check("mid_rst_sum", 32'(bus.rsp_sum), 0);
        check("mid_rst_id", 32'(bus.rsp_id), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_after_ready0", 32'(bus.req_ready), 32'b0001);
        check("mid_after_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp("mid_r0");
        check("mid_r0_sum", 32'(bus.rsp_sum), 3);
        check("mid_r0_id", 32'(bus.rsp_id), 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("mid_r0_done", 32'(bus.rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
